// File: rtl/seq_mult_4x4.sv
// Sequential 4x4 unsigned shift-and-add multiplier driving one 4-bit ripple-carry adder stage.
// Four iterations per operation, single-cycle start/done handshake, 8-bit registered product.

module rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  always_comb begin
    logic c;
    c = cin;
    s = 4'b0;
    for (int i = 0; i < 4; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

module seq_mult_4x4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  mcand;
  logic [3:0]  acc;
  logic [3:0]  mq;
  logic [1:0]  cnt;

  logic [3:0]  add_b;
  logic [3:0]  add_s;
  logic        add_cout;
  logic [8:0]  shift_in;
  logic [7:0]  shifted;

  // Partial product is either the multiplicand or zero, picked by the current multiplier LSB.
  assign add_b = mq[0] ? mcand : 4'b0;

  rca4 u_add (
    .a    (acc),
    .b    (add_b),
    .cin  (1'b0),
    .s    (add_s),
    .cout (add_cout)
  );

  // Carry is kept as bit 8 so the shift moves it into acc[3] rather than dropping it.
  assign shift_in = {add_cout, add_s, mq};
  assign shifted  = shift_in[8:1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == 2'd3) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= 4'b0;
      acc   <= 4'b0;
      mq    <= 4'b0;
      cnt   <= 2'b0;
      p     <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= a;
            mq    <= b;
            acc   <= 4'b0;
            cnt   <= 2'b0;
          end
        end
        RUN: begin
          acc <= shifted[7:4];
          mq  <= shifted[3:0];
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) p <= shifted;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_mult_4x4.sv
// Directed bench for seq_mult_4x4: handshake timing, products, ignored start, mid-run reset.
`timescale 1ns/1ps

module tb_seq_mult_4x4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] p;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;

  seq_mult_4x4 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .p     (p),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = 4'd0; b = 4'd0;
    #2;
    tests++;
    if (p !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_async: p=%h busy=%b done=%b expected p=00 busy=0 done=0", p, busy, done);
    end
    tick; tick;
    rst = 1'b0;
    tick;
    tests++;
    if (p !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: p=%h busy=%b done=%b expected p=00 busy=0 done=0", p, busy, done);
    end
  endtask

  task automatic test_mult(input logic [3:0] ta, input logic [3:0] tb_v,
                           input logic [7:0] exp, input string name);
    a = ta; b = tb_v; start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL %s run_cycle%0d: busy=%b done=%b expected busy=1 done=0", name, k, busy, done);
      end
      tick;
    end
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || p !== exp) begin
      fails++;
      $display("FAIL %s done_cycle: done=%b busy=%b p=%h expected done=1 busy=0 p=%h", name, done, busy, p, exp);
    end
    tick;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || p !== exp) begin
      fails++;
      $display("FAIL %s after_done: done=%b busy=%b p=%h expected done=0 busy=0 p=%h", name, done, busy, p, exp);
    end
  endtask

  task automatic test_back_to_back;
    int pulses;
    pulses = 0;
    a = 4'd6; b = 4'd7; start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick;
      tests++;
      if (done !== (i % 6 == 5) || busy !== (i % 6 >= 1 && i % 6 <= 4)) begin
        fails++;
        $display("FAIL b2b_edge%0d: done=%b busy=%b expected done=%b busy=%b", i, done, busy,
                 (i % 6 == 5), (i % 6 >= 1 && i % 6 <= 4));
      end
      if (done === 1'b1) begin
        pulses++;
        tests++;
        if (p !== 8'h2A) begin
          fails++;
          $display("FAIL b2b_product_edge%0d: p=%h expected 2a", i, p);
        end
      end
    end
    tests++;
    if (pulses != 3) begin
      fails++;
      $display("FAIL b2b_pulse_count: got %0d expected 3", pulses);
    end
    start = 1'b0;
    tick; tick; tick;
    tests++;
    if (done !== 1'b1 || p !== 8'h2A) begin
      fails++;
      $display("FAIL b2b_drain: done=%b p=%h expected done=1 p=2a", done, p);
    end
    tick;
  endtask

  task automatic test_ignore_start;
    a = 4'd3; b = 4'd5; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    a = 4'd15; b = 4'd15; start = 1'b1;
    tick;
    start = 1'b0; a = 4'd0; b = 4'd0;
    tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL ignore_mid_run: busy=%b done=%b expected busy=1 done=0", busy, done);
    end
    tick; tick;
    tests++;
    if (done !== 1'b1 || p !== 8'h0F) begin
      fails++;
      $display("FAIL ignore_result: done=%b p=%h expected done=1 p=0f", done, p);
    end
    for (int i = 0; i < 6; i++) begin
      tick;
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || p !== 8'h0F) begin
        fails++;
        $display("FAIL ignore_no_relaunch%0d: busy=%b done=%b p=%h expected 0 0 0f", i, busy, done, p);
      end
    end
  endtask

  task automatic test_reset_mid_run;
    a = 4'd12; b = 4'd12; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    rst = 1'b1;
    #1;
    tests++;
    if (p !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL midrun_reset: p=%h busy=%b done=%b expected p=00 busy=0 done=0", p, busy, done);
    end
    tick;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      tests++;
      if (done !== 1'b0 || busy !== 1'b0 || p !== 8'h00) begin
        fails++;
        $display("FAIL midrun_no_done%0d: done=%b busy=%b p=%h expected 0 0 00", i, done, busy, p);
      end
    end
    test_mult(4'd12, 4'd12, 8'h90, "after_reset_12x12");
  endtask

  initial begin
    test_reset;
    test_mult(4'd13, 4'd11, 8'h8F, "mult_13x11");
    test_mult(4'd15, 4'd15, 8'hE1, "mult_15x15");
    test_mult(4'd0,  4'd9,  8'h00, "mult_0x9");
    test_mult(4'd9,  4'd0,  8'h00, "mult_9x0");
    test_back_to_back;
    test_ignore_start;
    test_reset_mid_run;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
